conv_output_serializer: RTL

CONV_OUTPUT_SERIALIZER -- requirements
Module: conv_output_serializer

---
 rtl/conv_output_serializer.sv | 88 ++++++++
 1 files changed

// File: rtl/conv_output_serializer.sv
// Buffers up to two parallel conv-layer vectors and streams them out one word per handshake.
// Build option: define CONV_SERIALIZER_RELU_EN to clamp negative output words to zero.
module conv_output_serializer #(
  parameter int N_CONVOLUTIONS      = 256,
  parameter int WORD_SIZE           = 16,
  parameter int OUTPUT_LAYER_HEIGHT = 32
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic                                     valid_i,
  output logic                                     ready_o,
  input  logic [N_CONVOLUTIONS-1:0][WORD_SIZE-1:0] data_i,
  output logic                                     valid_o,
  input  logic                                     yumi_i,
  output logic [WORD_SIZE-1:0]                     data_o,
  output logic                                     last_o
);

  localparam int WORD_CNT_W = (N_CONVOLUTIONS > 1) ? $clog2(N_CONVOLUTIONS) : 1;
  localparam int VEC_CNT_W  = (OUTPUT_LAYER_HEIGHT > 1) ? $clog2(OUTPUT_LAYER_HEIGHT) : 1;
  localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(N_CONVOLUTIONS - 1);
  localparam logic [VEC_CNT_W-1:0]  LAST_VEC  = VEC_CNT_W'(OUTPUT_LAYER_HEIGHT - 1);

  logic [N_CONVOLUTIONS-1:0][WORD_SIZE-1:0] buffer [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occupancy;
  logic [WORD_CNT_W-1:0] word_cnt;
  logic [VEC_CNT_W-1:0]  vec_cnt;
  logic                  handshake_in;
  logic                  handshake_out;
  logic                  vector_done;
  logic [WORD_SIZE-1:0]  head_word;

  // ready_o comes straight from occupancy so it never combinationally follows valid_i or yumi_i.
  assign ready_o       = (occupancy < 2'd2);
  assign valid_o       = (occupancy != 2'd0);
  assign handshake_in  = valid_i && ready_o;
  assign handshake_out = valid_o && yumi_i;
  assign vector_done   = handshake_out && (word_cnt == LAST_WORD);

  assign head_word = buffer[rd_ptr][word_cnt];
  assign last_o    = valid_o && (word_cnt == LAST_WORD) && (vec_cnt == LAST_VEC);

`ifdef CONV_SERIALIZER_RELU_EN
  assign data_o = head_word[WORD_SIZE-1] ? '0 : head_word;
`else
  assign data_o = head_word;
`endif

  // Vector storage carries no reset; the pointers and occupancy decide what is live.
  always_ff @(posedge clk_i) begin
    if (handshake_in && !reset_i) begin
      buffer[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= 2'd0;
      word_cnt  <= '0;
      vec_cnt   <= '0;
    end else begin
      if (handshake_in) begin
        wr_ptr <= ~wr_ptr;
      end

      if (handshake_out) begin
        word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
      end

      if (vector_done) begin
        rd_ptr  <= ~rd_ptr;
        vec_cnt <= (vec_cnt == LAST_VEC) ? '0 : vec_cnt + 1'b1;
      end

      // A simultaneous push and pop leaves occupancy where it was.
      case ({handshake_in, vector_done})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule
